// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ALU between two requesters.
// A tag pipe follows each issued operation so its result is steered back to the issuer.
module alu_arbiter #(
  parameter int unsigned BITS    = 32,
  parameter int unsigned LATENCY = 1,
  parameter logic [31:0] NOP     = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_instr,
  input  logic [BITS-1:0] req0_a,
  input  logic [BITS-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_instr,
  input  logic [BITS-1:0] req1_a,
  input  logic [BITS-1:0] req1_b,
  output logic            resp0_valid,
  output logic            resp1_valid,
  output logic [BITS-1:0] resp_result,
  output logic [31:0]     alu_operation,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  input  logic [BITS-1:0] alu_result,
  output logic [2:0]      inflight
);

  logic               last_grant_q, last_grant_d;
  logic [LATENCY-1:0] v_q, v_d;
  logic [LATENCY-1:0] id_q, id_d;
  logic [2:0]         inflight_q, inflight_d;
  logic               gnt0_s, gnt1_s, hs_s, retire_s;

  // Grant: the requester that did not win last goes first when both ask
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst || flush) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      gnt0_s = last_grant_q;
      gnt1_s = ~last_grant_q;
    end else begin
      gnt0_s = req0_valid;
      gnt1_s = req1_valid;
    end
  end

  assign hs_s       = gnt0_s | gnt1_s;
  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;

  // ALU operand mux; idle cycles present a NOP with zero operands
  always_comb begin
    alu_operation = NOP;
    alu_a         = '0;
    alu_b         = '0;
    if (gnt0_s) begin
      alu_operation = req0_instr;
      alu_a         = req0_a;
      alu_b         = req0_b;
    end else if (gnt1_s) begin
      alu_operation = req1_instr;
      alu_a         = req1_a;
      alu_b         = req1_b;
    end else begin
      alu_operation = NOP;
      alu_a         = '0;
      alu_b         = '0;
    end
  end

  assign retire_s = v_q[LATENCY-1];

  // Tag pipe next state, occupancy count and round-robin pointer
  always_comb begin
    v_d          = '0;
    id_d         = '0;
    last_grant_d = last_grant_q;
    inflight_d   = inflight_q;
    if (flush) begin
      v_d        = '0;
      id_d       = '0;
      inflight_d = 3'd0;
    end else begin
      v_d[0]  = hs_s;
      id_d[0] = gnt1_s;
      for (int i = 1; i < int'(LATENCY); i++) begin
        v_d[i]  = v_q[i-1];
        id_d[i] = id_q[i-1];
      end
      inflight_d = inflight_q + {2'b00, hs_s} - {2'b00, retire_s};
    end
    if (hs_s) begin
      last_grant_d = gnt1_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q          <= '0;
      id_q         <= '0;
      inflight_q   <= 3'd0;
      last_grant_q <= 1'b1;
    end else begin
      v_q          <= v_d;
      id_q         <= id_d;
      inflight_q   <= inflight_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Results still in the pipe when reset arrives are never announced
  assign resp0_valid = retire_s && !id_q[LATENCY-1] && !rst;
  assign resp1_valid = retire_s &&  id_q[LATENCY-1] && !rst;
  assign resp_result = alu_result;
  assign inflight    = inflight_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance (parameter BITS; ports clk, operation, a, b, result) between two requesters, for example the execute stage and the address/branch-compare path.
- Arbitrates round-robin using valid/ready handshakes.
- Drives the ALU operation and operand ports and tracks in-flight operations through the ALU's fixed latency.
- Routes each result back to the requester that issued it. Supports a synchronous flush for pipeline redirects.

Parameters:
- BITS, 32, datapath width; must match the shared alu.
- LATENCY, 1, cycles from operands presented to alu result valid. Legal range is 1..4.
- NOP, 32'h00000013, instruction driven on alu_operation when no request is granted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all in-flight operations and block grants this cycle.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 granted; transfer when valid&&ready.
- req0_instr  in  32  requester 0 RV32 instruction word (opcode/funct3/funct7 used by alu).
- req0_a  in  BITS  requester 0 operand a.
- req0_b  in  BITS  requester 0 operand b.
- req1_valid, req1_ready, req1_instr, req1_a, req1_b: same as requester 0, for requester 1.
- resp0_valid  out  1  result for requester 0 on resp_result this cycle.
- resp1_valid  out  1  result for requester 1 on resp_result this cycle.
- resp_result  out  BITS  shared result bus (= alu_result).
- alu_operation  out  32  to alu operation.
- alu_a  out  BITS  to alu a.
- alu_b  out  BITS  to alu b.
- alu_result  in  BITS  from alu result.
- inflight  out  3  number of operations in the ALU pipe (0..LATENCY).

Behaviour:
- Reset (rst=1 at a clk edge):
  - Tag pipe is cleared and inflight=0.
  - last_grant=1, so requester 0 has first priority.
  - All outputs take their idle values: req*_ready=0, resp*_valid=0, alu_operation=NOP, alu_a=alu_b=0.
  - Reset mid-operation drops in-flight results; no resp*_valid is asserted for them.
- Grant (combinational):
  - Grants are disabled when rst or flush is high.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - At most one req*_ready is high per cycle. Ready never depends on a prior ready.
- Requester rule: a requester must hold valid and its payload stable until ready. The arbiter never drops a valid request.
- ALU drive (combinational):
  - With a grant: alu_operation/alu_a/alu_b = the granted requester's instr/a/b.
  - Otherwise: alu_operation=NOP, alu_a=alu_b=0.
- last_grant updates only on a handshake edge.
- Tag pipe:
  - Shift register of depth LATENCY, each entry {v, id}.
  - Stage 0 loads {handshake, granted id} every edge.
- Response:
  - The output stage drives resp0_valid = v&&id==0 and resp1_valid = v&&id==1.
  - resp_result = alu_result (combinational).
  - For a handshake in cycle T, the response appears in cycle T+LATENCY.
  - There is no response backpressure; requesters must accept.
- Throughput: one operation per cycle sustained, back-to-back, alternating requesters when both are valid.
- flush:
  - All tag-pipe v bits clear at that edge.
  - The cycle's grant is suppressed.
  - Responses in the flush cycle itself are still delivered.
  - The ALU keeps computing discarded ops; their results are ignored.
- inflight:
  - Registered count of set v bits.
  - +1 on handshake, −1 when an output-stage entry retires. Simultaneous ±1 leaves it unchanged.
  - Forced to 0 on flush or rst.
- Width: operands pass through unmodified. Result width is BITS, with no extension or truncation.

Test Plan:
- Single AND:
  - Stimulus: req0 instr=32'h00007033, a=32'h87654321, b=32'h89abcdef.
  - Response: req0_ready=1 the same cycle; resp0_valid=1 with resp_result=32'h81214121 exactly LATENCY cycles later; resp1_valid stays 0.
- Contention:
  - Stimulus: both valid after reset; req0 ADD (32'h00000033, same operands), req1 SLL (32'h00001033, b=32'h10).
  - Response: req0 granted first, req1 next cycle; responses are 32'h11111110 (resp0) then 32'h43210000 (resp1) on consecutive cycles.
- Sustained round-robin:
  - Stimulus: both valid for 8 cycles.
  - Response: grants alternate 0,1,0,1…; inflight=LATENCY in steady state; no cycle without a grant.
- Idle:
  - Stimulus: no valids.
  - Response: alu_operation=32'h00000013, alu_a=alu_b=0, no resp*_valid, inflight=0.
- Flush:
  - Stimulus: LATENCY=2, with 2 ops in flight; assert flush for 1 cycle while req1 is valid.
  - Response: req1_ready=0 that cycle; no resp for the flushed ops; inflight=0; req1 is granted the next cycle and its result is returned normally.
- Reset mid-op:
  - Stimulus: rst high one cycle after a handshake.
  - Response: no resp*_valid for that op; all outputs at reset values; first grant after reset goes to req0.
